// File: rtl/uart_pkg.sv
// uart_pkg: frame format, oversampling constants and FSM states shared by the UART transmitter and receiver
package uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_e;
  localparam int UART_OVERSAMPLE = 16;
  localparam int UART_SAMPLE_POINT = 7;
  localparam int UART_DATA_BITS = 8;
endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: write port from the UART receiver into its downstream receive FIFO
interface uart_rx_if;
  import uart_pkg::*;
  logic par_wr;
  logic [UART_DATA_BITS-1:0] par_wr_data;
  logic fifo_full;
  modport master (output par_wr, par_wr_data, input fifo_full);
  modport slave (input par_wr, par_wr_data, output fifo_full);
endinterface

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchroniser for ser_rx plus a falling-edge detector, all flops resetting to idle-high
module uart_rx_sync (
  input  logic pll_clk,
  input  logic reset_n,
  input  logic ser_rx,
  output logic rx_s,
  output logic rx_fall
);
  logic meta;
  logic rx_s_d;
  always_ff @(posedge pll_clk or negedge reset_n)
    if (!reset_n) {meta, rx_s, rx_s_d} <= '1;
    else {meta, rx_s, rx_s_d} <= {ser_rx, meta, rx_s};
  // a real edge is needed, so a line held low (break) cannot retrigger
  assign rx_fall = rx_s_d & ~rx_s;
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 oversampling UART receiver that writes good bytes to a FIFO and flags framing and overrun errors
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = UART_OVERSAMPLE,
  parameter int SAMPLE_POINT = UART_SAMPLE_POINT
) (
  input  logic      pll_clk,
  input  logic      reset_n,
  input  logic      ser_rx,
  uart_rx_if.master fifo,
  output logic      frame_err,
  output logic      overrun,
  output logic      rx_busy
);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] SP = CW'(SAMPLE_POINT);
  localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);
  localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);
  localparam logic [1:0] S_IDLE = 2'(IDLE);
  localparam logic [1:0] S_START = 2'(START);
  localparam logic [1:0] S_DATA = 2'(DATA);
  localparam logic [1:0] S_STOP = 2'(STOP);
  logic rx_s;
  logic rx_fall;
  logic [1:0] state;
  logic [CW-1:0] cnt;
  logic [2:0] bit_cnt;
  logic [UART_DATA_BITS-1:0] shreg;
  logic mid;
  logic last;
  logic good;
  uart_rx_sync u_sync (
    .pll_clk (pll_clk),
    .reset_n (reset_n),
    .ser_rx  (ser_rx),
    .rx_s    (rx_s),
    .rx_fall (rx_fall)
  );
  assign mid = cnt == SP;
  assign last = cnt == LAST;
  assign good = rx_s & ~fifo.fifo_full;
  assign rx_busy = state != S_IDLE;
  // cnt wraps to zero at LAST because OVERSAMPLE is a power of two, which clears it on START->DATA and DATA->STOP
  always_ff @(posedge pll_clk or negedge reset_n)
    if (!reset_n) begin
      state <= S_IDLE;
      cnt <= '0;
      bit_cnt <= '0;
      shreg <= '0;
      fifo.par_wr <= 1'b0;
      fifo.par_wr_data <= '0;
      frame_err <= 1'b0;
      overrun <= 1'b0;
    end else begin
      fifo.par_wr <= 1'b0;
      frame_err <= 1'b0;
      overrun <= 1'b0;
      cnt <= cnt + 1'b1;
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (rx_fall) state <= S_START;
        end
        S_START:
          if (mid && rx_s) begin
            state <= S_IDLE;
            cnt <= '0;
          end else if (last) begin
            state <= S_DATA;
            bit_cnt <= '0;
          end
        S_DATA: begin
          if (mid) shreg <= {rx_s, shreg[UART_DATA_BITS-1:1]};
          if (last) begin
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == LAST_BIT) state <= S_STOP;
          end
        end
        S_STOP:
          // leave mid stop bit so a back-to-back start edge is not missed
          if (mid) begin
            state <= S_IDLE;
            cnt <= '0;
            fifo.par_wr <= good;
            overrun <= rx_s & fifo.fifo_full;
            frame_err <= ~rx_s;
            if (good) fifo.par_wr_data <= shreg;
          end
        default: state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed and random 8N1 frames checked against an event model derived from the frame timing rules
module tb_uart_rx;
  localparam int OS = 16;
  localparam int PULSE_OFS = 155;
  typedef struct {int kind; logic [7:0] data; int cyc;} ev_t;
  logic pll_clk = 1'b0;
  logic reset_n = 1'b0;
  logic ser_rx = 1'b1;
  logic frame_err, overrun, rx_busy;
  uart_rx_if rx_if ();
  int cyc = 0;
  int errors = 0;
  int checks = 0;
  int busy_cnt = 0;
  logic [7:0] last_wr = 8'h00;
  ev_t obs[$];
  ev_t exp_q[$];

  uart_rx dut (
    .pll_clk   (pll_clk),
    .reset_n   (reset_n),
    .ser_rx    (ser_rx),
    .fifo      (rx_if),
    .frame_err (frame_err),
    .overrun   (overrun),
    .rx_busy   (rx_busy)
  );

  always #5 pll_clk = ~pll_clk;
  always @(posedge pll_clk) cyc <= cyc + 1;

  // kind: 0 write, 1 framing error, 2 overrun; data is par_wr_data seen during the pulse
  always @(negedge pll_clk)
    if (reset_n) begin
      if (rx_if.par_wr) obs.push_back('{0, rx_if.par_wr_data, cyc});
      if (frame_err) obs.push_back('{1, rx_if.par_wr_data, cyc});
      if (overrun) obs.push_back('{2, rx_if.par_wr_data, cyc});
      if (rx_busy) busy_cnt <= busy_cnt + 1;
    end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge pll_clk);
      #1;
    end
  endtask

  task automatic bit_out(input logic v);
    ser_rx = v;
    tick(OS);
  endtask

  // outcome and time of the one pulse follow from the stop bit and fifo_full during the stop bit
  task automatic send(input logic [7:0] b, input logic stop, input logic full_data, input logic full_stop);
    int c0;
    c0 = cyc;
    rx_if.fifo_full = full_data;
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(b[i]);
    rx_if.fifo_full = full_stop;
    if (stop && !full_stop) begin
      exp_q.push_back('{0, b, c0 + PULSE_OFS});
      last_wr = b;
    end else exp_q.push_back('{stop ? 2 : 1, last_wr, c0 + PULSE_OFS});
    bit_out(stop);
    rx_if.fifo_full = 1'b0;
  endtask

  task automatic check_events(input string tag);
    ev_t o, e;
    tick(4);
    chk({tag, " count"}, obs.size(), exp_q.size());
    while (obs.size() > 0 && exp_q.size() > 0) begin
      o = obs.pop_front();
      e = exp_q.pop_front();
      chk({tag, " kind"}, o.kind, e.kind);
      chk({tag, " data"}, {24'd0, o.data}, {24'd0, e.data});
      chk({tag, " cycle"}, o.cyc, e.cyc);
    end
    obs.delete();
    exp_q.delete();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " par_wr"}, {31'd0, rx_if.par_wr}, 0);
    chk({tag, " par_wr_data"}, {24'd0, rx_if.par_wr_data}, 0);
    chk({tag, " frame_err"}, {31'd0, frame_err}, 0);
    chk({tag, " overrun"}, {31'd0, overrun}, 0);
    chk({tag, " rx_busy"}, {31'd0, rx_busy}, 0);
  endtask

  initial begin
    logic [7:0] b;
    int r;
    rx_if.fifo_full = 1'b0;
    tick(3);
    chk_reset_outputs("reset");
    reset_n = 1'b1;
    tick(4);
    busy_cnt = 0;
    send(8'hA5, 1'b1, 1'b0, 1'b0);
    chk("single busy cycles", busy_cnt, 152);
    check_events("single");
    send(8'h00, 1'b1, 1'b0, 1'b0);
    send(8'hFF, 1'b1, 1'b0, 1'b0);
    check_events("back2back");
    busy_cnt = 0;
    ser_rx = 1'b0;
    tick(4);
    ser_rx = 1'b1;
    tick(12);
    chk("false start busy cycles", busy_cnt, 8);
    chk("false start idle", {31'd0, rx_busy}, 0);
    tick(20);
    check_events("false start");
    send(8'h3C, 1'b0, 1'b0, 1'b0);
    tick(60);
    ser_rx = 1'b1;
    tick(5);
    send(8'h5A, 1'b1, 1'b0, 1'b0);
    check_events("framing");
    send(8'h81, 1'b1, 1'b1, 1'b1);
    chk("overrun hold", {24'd0, rx_if.par_wr_data}, 32'h5A);
    send(8'hC3, 1'b1, 1'b1, 1'b0);
    check_events("overrun");
    for (int k = 0; k < 24; k++) begin
      b = 8'($urandom);
      r = int'($urandom_range(0, 9));
      send(b, r != 0, 1'($urandom_range(0, 1)), r == 1);
      ser_rx = 1'b1;
      tick(r != 0 ? int'($urandom_range(0, 4)) : 4);
    end
    check_events("random");
    bit_out(1'b0);
    for (int i = 0; i < 4; i++) bit_out(1'b0);
    ser_rx = 1'b1;
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("mid-frame reset");
    last_wr = 8'h00;
    tick(OS + OS / 2);
    reset_n = 1'b1;
    tick(OS / 2);
    bit_out(1'b1);
    bit_out(1'b1);
    bit_out(1'b1);
    tick(10);
    chk("post reset data", {24'd0, rx_if.par_wr_data}, 0);
    check_events("mid-frame reset");
    for (int i = 0; i < 256; i++) send(8'(i), 1'b1, 1'b0, 1'b0);
    check_events("loopback");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
